forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl.sv | 104 ++++++++++
 tb/tb_forward_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Tracks EX/MEM producers and emits registered EX operand-mux selects.
module forward_ctrl #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  ex_bubble
);

    typedef logic [REG_ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t rd;
        logic  regwrite;
        logic  memread;
    } ex_trk_t;

    typedef struct packed {
        logic  valid;
        addr_t rd;
        logic  regwrite;
    } mem_trk_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    ex_trk_t  ex_q;
    ex_trk_t  ex_d;
    mem_trk_t mem_q;
    logic     advance;
    logic     rs_hit;
    logic     rt_hit;
    logic [1:0] a_d;
    logic [1:0] b_d;

    // Newest producer wins; r0 is hard-wired and never forwarded.
    function automatic logic [1:0] pick(
        input addr_t    src,
        input ex_trk_t  ex,
        input mem_trk_t mem
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (src != '0) begin
            if (ex.valid && ex.regwrite && ex.rd == src)
                sel = SEL_MEM;
            else if (mem.valid && mem.regwrite && mem.rd == src)
                sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        rs_hit  = (ex_q.rd == id_rs);
        rt_hit  = (ex_q.rd == id_rt);
        stall   = id_valid && !flush && ex_q.valid && ex_q.memread
                  && (ex_q.rd != '0) && (rs_hit || rt_hit);
        advance = id_valid && !stall && !flush;
    end

    always_comb begin
        ex_d = '0;
        a_d  = pick(id_rs, ex_q, mem_q);
        b_d  = pick(id_rt, ex_q, mem_q);
        if (advance) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else begin
            mem_q.valid    <= ex_q.valid;
            mem_q.rd       <= ex_q.rd;
            mem_q.regwrite <= ex_q.regwrite;
            ex_q           <= ex_d;
            fwd_a_sel      <= advance ? a_d : SEL_RF;
            fwd_b_sel      <= advance ? b_d : SEL_RF;
        end
    end

    assign ex_bubble = !ex_q.valid;

endmodule

// File: tb/tb_forward_ctrl.sv
// Randomized and directed bench for forward_ctrl against a
// pipeline-occupancy reference model.
module tb_forward_ctrl;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         id_valid;
    logic [W-1:0] id_rs;
    logic [W-1:0] id_rt;
    logic [W-1:0] id_rd;
    logic         id_regwrite;
    logic         id_memread;
    logic         flush;
    logic [1:0]   fwd_a_sel;
    logic [1:0]   fwd_b_sel;
    logic         stall;
    logic         ex_bubble;

    forward_ctrl #(.REG_ADDR_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .flush      (flush),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall),
        .ex_bubble  (ex_bubble)
    );

    always #5 clk = ~clk;

    // One occupant of a pipeline stage: an instruction or a bubble,
    // plus the selects it was expected to receive when it left ID.
    typedef struct {
        bit valid;
        int rd;
        bit rw;
        bit mr;
        int sa;
        int sb;
    } slot_t;

    slot_t ex_s;
    slot_t mem_s;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic slot_t bubble();
        slot_t s;
        s = '{0, 0, 0, 0, 0, 0};
        return s;
    endfunction

    // Which stage supplies register r, scanning newest to oldest.
    function automatic int src_sel(input int r);
        if (r == 0) return 0;
        if (ex_s.valid && ex_s.rw && ex_s.rd == r) return 1;
        if (mem_s.valid && mem_s.rw && mem_s.rd == r) return 2;
        return 0;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt,
                         input int rd, input bit rw, input bit mr,
                         input bit fl);
        id_valid    = v;
        id_rs       = W'(rs);
        id_rt       = W'(rt);
        id_rd       = W'(rd);
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
    endtask

    task automatic cycle(input bit v, input int rs, input int rt,
                         input int rd, input bit rw, input bit mr,
                         input bit fl);
        bit    exp_st;
        slot_t nx;
        @(negedge clk);
        check("a_sel", fwd_a_sel, ex_s.sa);
        check("b_sel", fwd_b_sel, ex_s.sb);
        check("ex_bubble", ex_bubble, ex_s.valid ? 0 : 1);
        drive(v, rs, rt, rd, rw, mr, fl);
        #1;
        exp_st = v && !fl && ex_s.valid && ex_s.mr && ex_s.rd != 0
                 && (ex_s.rd == rs || ex_s.rd == rt);
        check("stall", stall, exp_st ? 1 : 0);
        nx = bubble();
        if (v && !exp_st && !fl)
            nx = '{1, rd, rw, mr, src_sel(rs), src_sel(rt)};
        mem_s = ex_s;
        ex_s  = nx;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic after_edge(input string tag, input int ea,
                              input int eb, input int ebub);
        @(posedge clk);
        #1;
        check({tag, "_a"}, fwd_a_sel, ea);
        check({tag, "_b"}, fwd_b_sel, eb);
        check({tag, "_bub"}, ex_bubble, ebub);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        ex_s  = bubble();
        mem_s = bubble();
        #1;
        check("rst_a", fwd_a_sel, 0);
        check("rst_b", fwd_b_sel, 0);
        check("rst_bub", ex_bubble, 1);
        check("rst_stall", stall, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ex_s  = bubble();
        mem_s = bubble();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // ALU back-to-back: add r3; sub r3 as rs
        cycle(1, 1, 2, 3, 1, 0, 0);
        cycle(1, 3, 4, 6, 1, 0, 0);
        after_edge("b2b", 1, 0, 0);
        idle(); idle();

        // one nop gap -> MEM/WB, two nops -> register file
        cycle(1, 1, 2, 3, 1, 0, 0);
        idle();
        cycle(1, 7, 3, 8, 1, 0, 0);
        after_edge("gap1", 0, 2, 0);
        cycle(1, 1, 2, 3, 1, 0, 0);
        idle(); idle();
        cycle(1, 7, 3, 8, 1, 0, 0);
        after_edge("gap2", 0, 0, 0);
        idle(); idle();

        // double producer, newest wins
        cycle(1, 1, 2, 3, 1, 0, 0);
        cycle(1, 4, 5, 3, 1, 0, 0);
        cycle(1, 3, 3, 9, 1, 0, 0);
        after_edge("dbl", 1, 1, 0);
        idle(); idle();

        // load-use: one stall, a bubble, then MEM/WB select
        cycle(1, 0, 0, 5, 1, 1, 0);
        cycle(1, 5, 1, 6, 1, 0, 0);
        check("lu_stall", stall, 1);
        cycle(1, 5, 1, 6, 1, 0, 0);
        check("lu_nostall", stall, 0);
        after_edge("lu", 2, 0, 0);
        idle(); idle();

        // r0 is never forwarded
        cycle(1, 1, 2, 0, 1, 0, 0);
        cycle(1, 0, 0, 4, 1, 0, 0);
        after_edge("r0", 0, 0, 0);
        idle(); idle();

        // flush beats a pending load-use
        cycle(1, 0, 0, 5, 1, 1, 0);
        cycle(1, 5, 5, 6, 1, 0, 1);
        check("fl_stall", stall, 0);
        after_edge("fl", 0, 0, 1);
        idle(); idle();

        // reset dropped during a stall
        cycle(1, 0, 0, 5, 1, 1, 0);
        @(negedge clk);
        drive(1, 5, 0, 6, 1, 0, 0);
        #1;
        check("mid_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", stall, 0);
        check("mid_rst_bub", ex_bubble, 1);
        check("mid_rst_a", fwd_a_sel, 0);
        do_reset();
        cycle(1, 5, 5, 6, 1, 0, 0);
        after_edge("post_rst", 0, 0, 0);

        // randomized traffic on a small register window
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(7, 0) != 0,
                  int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 0)),
                  $urandom_range(3, 0) != 0,
                  $urandom_range(2, 0) == 0,
                  $urandom_range(9, 0) == 0);
            if ($urandom_range(99, 0) == 0)
                do_reset();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
